// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file.
// Selects the MEM/WB result, commits it, and serves two bypassed ID read ports.
module wb_regfile #(
   parameter int WORD_LEN          = 32,
   parameter int REG_FILE_ADDR_LEN = 5,
   parameter int CNT_LEN           = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         WB_EN,
   input  logic                         Mem_Read_EN,
   input  logic [WORD_LEN-1:0]          ALU_Result,
   input  logic [WORD_LEN-1:0]          Data_memory,
   input  logic [REG_FILE_ADDR_LEN-1:0] Dest,
   input  logic [REG_FILE_ADDR_LEN-1:0] src1,
   input  logic [REG_FILE_ADDR_LEN-1:0] src2,
   output logic [WORD_LEN-1:0]          reg1,
   output logic [WORD_LEN-1:0]          reg2,
   output logic [WORD_LEN-1:0]          WB_Value,
   output logic                         WB_Commit,
   output logic                         WB_EN_d,
   output logic [WORD_LEN-1:0]          WB_Value_d,
   output logic [REG_FILE_ADDR_LEN-1:0] WB_Dest_d,
   output logic [CNT_LEN-1:0]           Retire_Count
);

   localparam int DEPTH = 2 ** REG_FILE_ADDR_LEN;

   logic [WORD_LEN-1:0] regs [DEPTH];

   assign WB_Value  = Mem_Read_EN ? Data_memory : ALU_Result;
   // Writes to r0 and writes during reset never commit, so they also never bypass.
   assign WB_Commit = WB_EN && (Dest != '0) && !rst;

   always_comb begin
      reg1 = '0;
      if (src1 == '0)
         reg1 = '0;
      else if (WB_Commit && (src1 == Dest))
         reg1 = WB_Value;
      else
         reg1 = regs[src1];
   end

   always_comb begin
      reg2 = '0;
      if (src2 == '0)
         reg2 = '0;
      else if (WB_Commit && (src2 == Dest))
         reg2 = WB_Value;
      else
         reg2 = regs[src2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         WB_EN_d      <= 1'b0;
         WB_Value_d   <= '0;
         WB_Dest_d    <= '0;
         Retire_Count <= '0;
      end else begin
         if (WB_Commit) begin
            regs[Dest]   <= WB_Value;
            Retire_Count <= Retire_Count + CNT_LEN'(1);
         end
         // Data copies follow every cycle; consumers qualify them with WB_EN_d.
         WB_EN_d    <= WB_Commit;
         WB_Value_d <= WB_Value;
         WB_Dest_d  <= Dest;
      end
   end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus a randomized run
// against an array-based architectural model; a 4-bit-counter instance checks wrap.
module tb_wb_regfile;

   logic        clk;
   logic        rst;
   logic        wb_en;
   logic        mem_read_en;
   logic [31:0] alu_result;
   logic [31:0] data_memory;
   logic [4:0]  dest;
   logic [4:0]  src1;
   logic [4:0]  src2;

   logic [31:0] reg1, reg2, wb_value, wb_value_d;
   logic        wb_commit, wb_en_d;
   logic [4:0]  wb_dest_d;
   logic [31:0] retire_count;

   logic [31:0] s_reg1, s_reg2, s_wb_value, s_wb_value_d;
   logic        s_wb_commit, s_wb_en_d;
   logic [4:0]  s_wb_dest_d;
   logic [3:0]  s_retire_count;

   int checks = 0;
   int errors = 0;

   // Architectural model
   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;
   logic        m_en_d;
   logic [31:0] m_val_d;
   logic [4:0]  m_dest_d;

   wb_regfile dut (
      .clk(clk), .rst(rst), .WB_EN(wb_en), .Mem_Read_EN(mem_read_en),
      .ALU_Result(alu_result), .Data_memory(data_memory), .Dest(dest),
      .src1(src1), .src2(src2), .reg1(reg1), .reg2(reg2),
      .WB_Value(wb_value), .WB_Commit(wb_commit), .WB_EN_d(wb_en_d),
      .WB_Value_d(wb_value_d), .WB_Dest_d(wb_dest_d), .Retire_Count(retire_count)
   );

   wb_regfile #(.CNT_LEN(4)) dut_small (
      .clk(clk), .rst(rst), .WB_EN(wb_en), .Mem_Read_EN(mem_read_en),
      .ALU_Result(alu_result), .Data_memory(data_memory), .Dest(dest),
      .src1(src1), .src2(src2), .reg1(s_reg1), .reg2(s_reg2),
      .WB_Value(s_wb_value), .WB_Commit(s_wb_commit), .WB_EN_d(s_wb_en_d),
      .WB_Value_d(s_wb_value_d), .WB_Dest_d(s_wb_dest_d), .Retire_Count(s_retire_count)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] m_wbval();
      return mem_read_en ? data_memory : alu_result;
   endfunction

   function automatic logic m_commit();
      return wb_en && (dest != 5'd0) && !rst;
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] src);
      if (src == 5'd0) return 32'd0;
      if (m_commit() && src == dest) return m_wbval();
      return m_regs[src];
   endfunction

   // Advance one edge and apply the architectural effect of the current inputs.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         m_cnt = 0; m_en_d = 0; m_val_d = 0; m_dest_d = 0;
      end else begin
         if (m_commit()) begin
            m_regs[dest] = m_wbval();
            m_cnt = m_cnt + 1;
         end
         m_en_d = m_commit();
         m_val_d = m_wbval();
         m_dest_d = dest;
      end
      #1;
   endtask

   task automatic idle_inputs();
      wb_en = 0; mem_read_en = 0; alu_result = 0; data_memory = 0;
      dest = 0; src1 = 0; src2 = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1;
      tick(); tick();
      rst = 0;
      for (int i = 0; i < 32; i++) begin
         src1 = 5'(i); src2 = 5'(31 - i);
         #1;
         checks++;
         if (reg1 !== 32'd0 || reg2 !== 32'd0) begin
            errors++;
            $display("FAIL reset_read addr %0d: got %h/%h expected 0", i, reg1, reg2);
         end
      end
      checks++;
      if (retire_count !== 32'd0 || wb_en_d !== 1'b0 || s_retire_count !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: count %0d en_d %b small %0d expected 0 0 0",
                  retire_count, wb_en_d, s_retire_count);
      end
   endtask

   task automatic test_bypass();
      wb_en = 1; mem_read_en = 0; alu_result = 32'h0000_1234; dest = 5; src1 = 5; src2 = 0;
      #1;
      checks++;
      if (reg1 !== 32'h1234 || wb_commit !== 1'b1) begin
         errors++;
         $display("FAIL bypass: reg1 %h commit %b expected 00001234 1", reg1, wb_commit);
      end
      tick();
      wb_en = 0;
      #1;
      checks++;
      if (reg1 !== 32'h1234 || wb_en_d !== 1'b1 || wb_value_d !== 32'h1234 ||
          wb_dest_d !== 5'd5 || retire_count !== 32'd1) begin
         errors++;
         $display("FAIL after_commit: reg1 %h en_d %b val_d %h dest_d %0d cnt %0d expected 1234 1 1234 5 1",
                  reg1, wb_en_d, wb_value_d, wb_dest_d, retire_count);
      end
   endtask

   task automatic test_mem_read();
      wb_en = 1; mem_read_en = 1; data_memory = 32'hDEAD_BEEF; alu_result = 32'h1111_1111; dest = 31;
      #1;
      checks++;
      if (wb_value !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL mem_sel: got %h expected deadbeef", wb_value);
      end
      tick();
      wb_en = 0; dest = 30; src1 = 31; src2 = 30;
      #1;
      checks++;
      if (reg1 !== 32'hDEAD_BEEF || reg2 !== 32'd0 || wb_commit !== 1'b0) begin
         errors++;
         $display("FAIL mem_write: r31 %h r30 %h commit %b expected deadbeef 0 0", reg1, reg2, wb_commit);
      end
      tick();
      checks++;
      if (reg2 !== 32'd0 || retire_count !== 32'd2 || wb_en_d !== 1'b0) begin
         errors++;
         $display("FAIL no_write: r30 %h cnt %0d en_d %b expected 0 2 0", reg2, retire_count, wb_en_d);
      end
   endtask

   task automatic test_dest_zero();
      wb_en = 1; mem_read_en = 0; alu_result = 32'hFFFF_FFFF; dest = 0; src1 = 0; src2 = 0;
      #1;
      checks++;
      if (reg1 !== 32'd0 || reg2 !== 32'd0 || wb_commit !== 1'b0) begin
         errors++;
         $display("FAIL r0_read: %h/%h commit %b expected 0 0 0", reg1, reg2, wb_commit);
      end
      tick();
      wb_en = 0;
      #1;
      checks++;
      if (wb_en_d !== 1'b0 || retire_count !== 32'd2) begin
         errors++;
         $display("FAIL r0_drop: en_d %b cnt %0d expected 0 2", wb_en_d, retire_count);
      end
   endtask

   task automatic test_reset_priority();
      logic [31:0] v;
      wb_en = 1; mem_read_en = 0; alu_result = 32'hA5A5_A5A5; dest = 7;
      tick();
      rst = 1; alu_result = 32'h5A5A_5A5A; src1 = 7;
      #1;
      checks++;
      if (wb_commit !== 1'b0 || reg1 !== 32'hA5A5_A5A5) begin
         errors++;
         $display("FAIL rst_no_bypass: commit %b reg1 %h expected 0 a5a5a5a5", wb_commit, reg1);
      end
      tick();
      rst = 0; wb_en = 0;
      #1;
      checks++;
      if (reg1 !== 32'd0 || retire_count !== 32'd0 || wb_en_d !== 1'b0) begin
         errors++;
         $display("FAIL rst_priority: r7 %h cnt %0d en_d %b expected 0 0 0", reg1, retire_count, wb_en_d);
      end
      v = $urandom;
      wb_en = 1; alu_result = v; dest = 3; src1 = 3;
      tick();
      wb_en = 0;
      #1;
      checks++;
      if (reg1 !== v || retire_count !== 32'd1 || s_retire_count !== 4'd1) begin
         errors++;
         $display("FAIL post_rst_write: r3 %h cnt %0d small %0d expected %h 1 1", reg1, retire_count, s_retire_count, v);
      end
   endtask

   task automatic test_wrap();
      idle_inputs();
      rst = 1;
      tick();
      rst = 0;
      for (int i = 0; i < 17; i++) begin
         wb_en = 1; alu_result = $urandom; dest = 5'((i + 1) % 32);
         tick();
      end
      wb_en = 0;
      #1;
      checks++;
      if (s_retire_count !== 4'd1 || retire_count !== 32'd17) begin
         errors++;
         $display("FAIL wrap: small %0d wide %0d expected 1 17", s_retire_count, retire_count);
      end
   endtask

   task automatic test_back_to_back();
      wb_en = 1; mem_read_en = 0; dest = 9; src2 = 9; alu_result = 32'd1;
      #1;
      checks++;
      if (reg2 !== 32'd1) begin
         errors++;
         $display("FAIL b2b_first: got %h expected 1", reg2);
      end
      tick();
      alu_result = 32'd2;
      #1;
      checks++;
      if (reg2 !== 32'd2) begin
         errors++;
         $display("FAIL b2b_second: got %h expected 2", reg2);
      end
      tick();
      wb_en = 0;
      #1;
      checks++;
      if (reg2 !== 32'd2) begin
         errors++;
         $display("FAIL b2b_settled: got %h expected 2", reg2);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         wb_en = ($urandom_range(0, 3) != 0);
         mem_read_en = $urandom_range(0, 1);
         alu_result = $urandom; data_memory = $urandom;
         dest = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         src1 = ($urandom_range(0, 3) == 0) ? dest : 5'($urandom_range(0, 31));
         src2 = ($urandom_range(0, 3) == 0) ? src1 : 5'($urandom_range(0, 31));
         #1;
         checks++;
         if (reg1 !== m_read(src1) || reg2 !== m_read(src2) ||
             wb_value !== m_wbval() || wb_commit !== m_commit()) begin
            errors++;
            $display("FAIL rand_comb %0d: r1 %h/%h r2 %h/%h val %h/%h commit %b/%b (got/expected)",
                     n, reg1, m_read(src1), reg2, m_read(src2), wb_value, m_wbval(), wb_commit, m_commit());
         end
         checks++;
         if (wb_en_d !== m_en_d || retire_count !== m_cnt || s_retire_count !== m_cnt[3:0] ||
             (m_en_d && (wb_value_d !== m_val_d || wb_dest_d !== m_dest_d))) begin
            errors++;
            $display("FAIL rand_regd %0d: en_d %b/%b cnt %0d/%0d small %0d val_d %h/%h dest_d %0d/%0d (got/expected)",
                     n, wb_en_d, m_en_d, retire_count, m_cnt, s_retire_count, wb_value_d, m_val_d,
                     wb_dest_d, m_dest_d);
         end
         tick();
      end
      rst = 0;
   endtask

   initial begin
      rst = 1;
      idle_inputs();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_cnt = 0; m_en_d = 0; m_val_d = 0; m_dest_d = 0;
      test_reset();
      test_bypass();
      test_mem_read();
      test_dest_zero();
      test_reset_priority();
      test_wrap();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
